// File: rtl/sweep_pkg.sv
// Shared types and clamped arithmetic for the frequency sweep sequencer.
package sweep_pkg;

    // IDLE | waiting for a valid start
    // PRIME| one cycle of generator phase clear before the sweep
    // UP   | incr stepping from lo towards hi
    // DOWN | incr stepping from hi back towards lo
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } state_t;

    // Arithmetic is done one bit wider than the widest supported operand so
    // neither the sum nor the borrow is lost before clamping.
    localparam int CALC_W = 32;

    // Upward step, clamped into [lo,hi]
    function automatic logic [CALC_W-1:0] sat_add(
        input logic [CALC_W-1:0] a,
        input logic [CALC_W-1:0] step,
        input logic [CALC_W-1:0] lo,
        input logic [CALC_W-1:0] hi
    );
        logic [CALC_W:0]   sum;
        logic [CALC_W-1:0] res;
        sum = {1'b0, a} + {1'b0, step};
        if (sum > {1'b0, hi})
            res = hi;
        else if (sum < {1'b0, lo})
            res = lo;
        else
            res = sum[CALC_W-1:0];
        return res;
    endfunction

    // Downward step, clamped into [lo,hi]; a borrow counts as below lo
    function automatic logic [CALC_W-1:0] sat_sub(
        input logic [CALC_W-1:0] a,
        input logic [CALC_W-1:0] step,
        input logic [CALC_W-1:0] lo,
        input logic [CALC_W-1:0] hi
    );
        logic [CALC_W:0]   diff;
        logic [CALC_W-1:0] res;
        diff = {1'b0, a} - {1'b0, step};
        if (diff[CALC_W] || (diff[CALC_W-1:0] < lo))
            res = lo;
        else if (diff[CALC_W-1:0] > hi)
            res = hi;
        else
            res = diff[CALC_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell down-counter: load has priority, decrements to zero and stops there.
module dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,        // active low, asynchronous
    input  logic               i_load,
    input  logic               i_dec,
    input  logic [DWELL_W-1:0] i_load_val,
    output logic               o_expired
);

    logic [DWELL_W-1:0] r_count;

    // Reload on request, otherwise count down while enabled
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_dec && (r_count != '0))
            r_count <= r_count - DWELL_W'(1);
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// Stepped up/down frequency sweep sequencer driving the sine generator.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int W       = 8,
    parameter int DWELL_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,        // active low, asynchronous
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [W-1:0]       i_cfg_lo,
    input  logic [W-1:0]       i_cfg_hi,
    input  logic [W-1:0]       i_cfg_step,
    input  logic [DWELL_W-1:0] i_cfg_dwell,
    input  logic [W-1:0]       i_cfg_offset,
    input  logic               i_cfg_loop,
    output logic [W-1:0]       o_incr,
    output logic [W-1:0]       o_offset,
    output logic               o_gen_en,
    output logic               o_gen_clr,
    output logic               o_busy,
    output logic               o_done
);

    state_t             r_state;
    logic [W-1:0]       r_lo;
    logic [W-1:0]       r_hi;
    logic [W-1:0]       r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic [W-1:0]       r_cfg_offset;
    logic               r_loop;
    logic [W-1:0]       r_incr;
    logic [W-1:0]       r_offset;
    logic               r_gen_en;
    logic               r_gen_clr;
    logic               r_busy;
    logic               r_done;

    logic               w_cfg_valid;
    logic               w_active;
    logic               w_expired;
    logic               w_timer_load;
    logic               w_timer_dec;
    logic [W-1:0]       w_up_next;
    logic [W-1:0]       w_down_next;
    logic [W-1:0]       w_turn_down;
    logic [W-1:0]       w_turn_up;

    assign w_cfg_valid = (i_cfg_step != '0) && (i_cfg_lo <= i_cfg_hi);
    assign w_active    = (r_state == UP) || (r_state == DOWN);

    // Every expiry changes (or at lo==hi re-issues) incr, so it always reloads
    assign w_timer_load = !i_abort && ((r_state == PRIME) || (w_active && w_expired));
    assign w_timer_dec  = w_active;

    assign w_up_next   = W'(sat_add(CALC_W'(r_incr), CALC_W'(r_step), CALC_W'(r_lo), CALC_W'(r_hi)));
    assign w_down_next = W'(sat_sub(CALC_W'(r_incr), CALC_W'(r_step), CALC_W'(r_lo), CALC_W'(r_hi)));
    assign w_turn_down = W'(sat_sub(CALC_W'(r_hi),   CALC_W'(r_step), CALC_W'(r_lo), CALC_W'(r_hi)));
    assign w_turn_up   = W'(sat_add(CALC_W'(r_lo),   CALC_W'(r_step), CALC_W'(r_lo), CALC_W'(r_hi)));

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_timer_load),
        .i_dec      (w_timer_dec),
        .i_load_val (r_dwell),
        .o_expired  (w_expired)
    );

    // Sweep FSM with shadow config and registered generator controls
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= IDLE;
            r_lo         <= '0;
            r_hi         <= '0;
            r_step       <= '0;
            r_dwell      <= '0;
            r_cfg_offset <= '0;
            r_loop       <= 1'b0;
            r_incr       <= '0;
            r_offset     <= '0;
            r_gen_en     <= 1'b0;
            r_gen_clr    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_gen_clr <= 1'b0;
            r_done    <= 1'b0;
            if ((r_state != IDLE) && i_abort) begin
                // incr and offset deliberately keep their last values
                r_state  <= IDLE;
                r_gen_en <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start && !i_abort && w_cfg_valid) begin
                            r_lo         <= i_cfg_lo;
                            r_hi         <= i_cfg_hi;
                            r_step       <= i_cfg_step;
                            r_dwell      <= i_cfg_dwell;
                            r_cfg_offset <= i_cfg_offset;
                            r_loop       <= i_cfg_loop;
                            r_gen_clr    <= 1'b1;
                            r_gen_en     <= 1'b0;
                            r_busy       <= 1'b1;
                            r_state      <= PRIME;
                        end
                    end
                    PRIME: begin
                        r_offset <= r_cfg_offset;
                        r_incr   <= r_lo;
                        r_gen_en <= 1'b1;
                        r_state  <= UP;
                    end
                    UP: begin
                        if (w_expired) begin
                            if (r_incr == r_hi) begin
                                r_incr  <= w_turn_down;
                                r_state <= DOWN;
                            end else begin
                                r_incr <= w_up_next;
                            end
                        end
                    end
                    DOWN: begin
                        if (w_expired) begin
                            if (r_incr != r_lo) begin
                                r_incr <= w_down_next;
                            end else if (r_loop) begin
                                r_incr  <= w_turn_up;
                                r_state <= UP;
                            end else begin
                                r_gen_en <= 1'b0;
                                r_busy   <= 1'b0;
                                r_done   <= 1'b1;
                                r_state  <= IDLE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_incr    = r_incr;
    assign o_offset  = r_offset;
    assign o_gen_en  = r_gen_en;
    assign o_gen_clr = r_gen_clr;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl with a per-cycle incr scoreboard.
module tb_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  cfg_lo;
    logic [7:0]  cfg_hi;
    logic [7:0]  cfg_step;
    logic [15:0] cfg_dwell;
    logic [7:0]  cfg_offset;
    logic        cfg_loop;
    logic [7:0]  incr;
    logic [7:0]  offset;
    logic        gen_en;
    logic        gen_clr;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    sweep_ctrl #(.W(8), .DWELL_W(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_abort      (abort),
        .i_cfg_lo     (cfg_lo),
        .i_cfg_hi     (cfg_hi),
        .i_cfg_step   (cfg_step),
        .i_cfg_dwell  (cfg_dwell),
        .i_cfg_offset (cfg_offset),
        .i_cfg_loop   (cfg_loop),
        .o_incr       (incr),
        .o_offset     (offset),
        .o_gen_en     (gen_en),
        .o_gen_clr    (gen_clr),
        .o_busy       (busy),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int lo, input int hi, input int step, input int dwell,
                           input int off, input logic loop);
        cfg_lo     = 8'(lo);
        cfg_hi     = 8'(hi);
        cfg_step   = 8'(step);
        cfg_dwell  = 16'(dwell);
        cfg_offset = 8'(off);
        cfg_loop   = loop;
    endtask

    // Expected one-shot incr sequence, each value repeated dwell+1 times
    task automatic push_sweep(input int lo, input int hi, input int step, input int dwell);
        int v;
        int seq[$];
        v = lo;
        seq.push_back(v);
        while (v != hi) begin
            v = (v + step > hi) ? hi : v + step;
            seq.push_back(v);
        end
        v = (hi - step < lo) ? lo : hi - step;
        seq.push_back(v);
        while (v != lo) begin
            v = (v - step < lo) ? lo : v - step;
            seq.push_back(v);
        end
        foreach (seq[i])
            for (int r = 0; r <= dwell; r++)
                exp_q.push_back(seq[i]);
    endtask

    // Leaves the bench #1 after the edge that samples start (PRIME cycle)
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic check_prime(input string tag);
        @(negedge clk);
        chk({tag, "_prime"}, {gen_en, gen_clr, busy, done}, 4'b0110);
    endtask

    task automatic check_steps(input string tag, input int n);
        int e;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_queue_empty"}, 1, 0);
                return;
            end
            e = exp_q.pop_front();
            @(negedge clk);
            chk({tag, "_incr"}, incr, e);
            chk({tag, "_ctl"}, {gen_en, gen_clr, busy, done}, 4'b1010);
        end
    endtask

    task automatic check_done(input string tag, input int exp_off);
        @(negedge clk);
        chk({tag, "_done"}, {gen_en, gen_clr, busy, done}, 4'b0001);
        chk({tag, "_offset"}, offset, exp_off);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {gen_en, gen_clr, busy, done}, 4'b0000);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(4, 12, 4, 1, 8'h5A, 1'b0);
        #3;
        chk("reset_outputs", {incr, offset, gen_en, gen_clr, busy, done}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {gen_en, gen_clr, busy, done}, 0);

        // 1: basic one-shot sweep with dwell 1
        set_cfg(4, 12, 4, 1, 8'h5A, 1'b0);
        push_sweep(4, 12, 4, 1);
        pulse_start();
        check_prime("s1");
        check_steps("s1", exp_q.size());
        check_done("s1", 8'h5A);

        // 2: near the top of the range, no wrap past 255
        set_cfg(250, 255, 4, 0, 8'h11, 1'b0);
        push_sweep(250, 255, 4, 0);
        pulse_start();
        check_prime("s2");
        check_steps("s2", exp_q.size());
        check_done("s2", 8'h11);

        // 3: invalid configs ignore start
        set_cfg(4, 12, 0, 1, 0, 1'b0);
        @(posedge clk); #1 start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s3_step0", {gen_en, gen_clr, busy, done}, 0);
        end
        set_cfg(9, 3, 1, 1, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s3_lo_gt_hi", {gen_en, gen_clr, busy, done}, 0);
        end
        #1 start = 1'b0;

        // 4: looped 0/8 sweep, abort on the 5th active cycle
        set_cfg(0, 8, 8, 0, 8'h22, 1'b1);
        exp_q.push_back(0); exp_q.push_back(8); exp_q.push_back(0);
        exp_q.push_back(8); exp_q.push_back(0);
        pulse_start();
        check_prime("s4");
        check_steps("s4", 5);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s4_abort_ctl", {gen_en, gen_clr, busy, done}, 0);
            chk("s4_abort_incr", incr, 0);
            chk("s4_abort_offset", offset, 8'h22);
        end

        // 5: config changes after start are ignored; start+abort in IDLE
        set_cfg(4, 12, 4, 1, 8'h33, 1'b0);
        push_sweep(4, 12, 4, 1);
        pulse_start();
        set_cfg(0, 20, 1, 3, 8'h77, 1'b1);
        check_prime("s5");
        check_steps("s5", exp_q.size());
        check_done("s5", 8'h33);
        set_cfg(4, 12, 4, 1, 8'h33, 1'b0);
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s5_start_abort", {gen_en, gen_clr, busy, done}, 0);
        end

        // Abort mid-UP holds a non-zero incr
        push_sweep(4, 12, 4, 1);
        pulse_start();
        check_prime("s7");
        check_steps("s7", 5);
        exp_q.delete();
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s7_abort_ctl", {gen_en, gen_clr, busy, done}, 0);
            chk("s7_abort_incr", incr, 12);
        end

        // 6: async reset in DOWN, then scenario 1 repeats exactly
        set_cfg(4, 12, 4, 1, 8'h5A, 1'b0);
        push_sweep(4, 12, 4, 1);
        pulse_start();
        check_prime("s6");
        check_steps("s6", 7);
        exp_q.delete();
        #2 rst = 1'b0;
        #1;
        chk("s6_async_reset", {incr, offset, gen_en, gen_clr, busy, done}, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s6_no_autostart", {gen_en, gen_clr, busy, done}, 0);
        end
        push_sweep(4, 12, 4, 1);
        pulse_start();
        check_prime("s6r");
        check_steps("s6r", exp_q.size());
        check_done("s6r", 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
